// File: rtl/fifo8_word_pkg.sv
// fifo8_word_pkg: shared sizing constants and the one-hot write decode
// used by the 8-entry first-word-fall-through word FIFO.
//   WIDTH_DEFAULT : default word width
//   DEPTH         : number of storage entries (8)
//   PTR_W         : read/write pointer width (3, free-running mod 8)
//   CNT_W         : occupancy counter width (4, holds 0..8)
package fifo8_word_pkg;

  localparam int WIDTH_DEFAULT = 16;
  localparam int DEPTH         = 8;
  localparam int PTR_W         = 3;
  localparam int CNT_W         = 4;

  // DMux8Way-style decode: steer a single enable onto one of eight lines.
  function automatic logic [DEPTH-1:0] onehot8(input logic [PTR_W-1:0] sel);
    logic [DEPTH-1:0] one;
    one = DEPTH'(1);
    return one << sel;
  endfunction

endpackage

// File: rtl/fifo8_word_if.sv
// fifo8_word_if: producer/consumer bus of the word FIFO.
//   in, push, pop                            : driven by the master (bench / producer+consumer)
//   out, full, empty, count, overflow, underflow : driven by the slave (the FIFO)
interface fifo8_word_if
  import fifo8_word_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);

  logic [WIDTH-1:0] in;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] out;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             underflow;

  modport master (
    output in, push, pop,
    input  out, full, empty, count, overflow, underflow
  );

  modport slave (
    input  in, push, pop,
    output out, full, empty, count, overflow, underflow
  );

endinterface

// File: rtl/fifo8_word_mux8way16.sv
// fifo8_word_mux8way16: Mux8Way16-style read select cell.
//   d   : eight WIDTH-bit inputs
//   sel : 3-bit select
//   y   : d[sel]
module fifo8_word_mux8way16
  import fifo8_word_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] d [DEPTH],
  input  logic [PTR_W-1:0] sel,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = d[0];
    case (sel)
      3'd0:    y = d[0];
      3'd1:    y = d[1];
      3'd2:    y = d[2];
      3'd3:    y = d[3];
      3'd4:    y = d[4];
      3'd5:    y = d[5];
      3'd6:    y = d[6];
      3'd7:    y = d[7];
      default: y = d[0];
    endcase
  end

endmodule

// File: rtl/fifo8_word.sv
// fifo8_word: 8-entry, WIDTH-bit first-word-fall-through FIFO.
//   clock : single clock, rising edge
//   reset : asynchronous, active-high; clears pointers, count and sticky flags
//   bus   : fifo8_word_if.slave
//     in/push  : write word / write request
//     pop      : advance head
//     out      : head word (0 when empty), combinational from storage only
//     full/empty/count : occupancy, all decoded from the registered count
//     overflow  : sticky, push dropped because full
//     underflow : sticky, pop attempted while empty
module fifo8_word
  import fifo8_word_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic         clock,
  input  logic         reset,
  fifo8_word_if.slave  bus
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic [DEPTH-1:0] wr_en;
  logic             full, empty;
  logic             push_acc, pop_acc;
  logic [WIDTH-1:0] head;

  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    empty    = (count_q == '0);
    // A full FIFO still takes a push when the head leaves in the same cycle.
    push_acc = bus.push && (!full || bus.pop);
    pop_acc  = bus.pop && !empty;
    wr_en    = push_acc ? onehot8(wr_ptr_q) : '0;

    // Pointers are free-running; the natural PTR_W-bit wrap gives mod 8.
    wr_ptr_d = wr_ptr_q + PTR_W'(push_acc);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_acc);

    count_d = count_q;
    if (push_acc && !pop_acc) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_acc && !push_acc) begin
      count_d = count_q - CNT_W'(1);
    end

    overflow_d  = overflow_q  | (bus.push && !push_acc);
    underflow_d = underflow_q | (bus.pop && empty);
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = wr_en[i] ? bus.in : mem_q[i];
    end
  end

  // Storage carries no reset; stale contents are masked by count.
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo8_word_mux8way16 #(.WIDTH(WIDTH)) u_read_mux (
    .d   (mem_q),
    .sel (rd_ptr_q),
    .y   (head)
  );

  assign bus.out       = empty ? '0 : head;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_fifo8_word.sv
// tb_fifo8_word: directed and randomized bench for fifo8_word against a
// queue-based reference model of the FIFO's externally visible behaviour.
module tb_fifo8_word;
  import fifo8_word_pkg::*;

  localparam int W = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;

  fifo8_word_if #(.WIDTH(W)) bus ();

  fifo8_word #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of stored words plus the two sticky flags.
  logic [W-1:0] q[$];
  bit           m_ovf = 1'b0;
  bit           m_unf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    logic [W-1:0] exp_out;
    int           sz;
    sz      = q.size();
    exp_out = (sz != 0) ? q[0] : '0;
    chk({ctx, "_out"},   32'(bus.out),       32'(exp_out));
    chk({ctx, "_count"}, 32'(bus.count),     32'(sz));
    chk({ctx, "_full"},  32'(bus.full),      32'(sz == 8));
    chk({ctx, "_empty"}, 32'(bus.empty),     32'(sz == 0));
    chk({ctx, "_ovf"},   32'(bus.overflow),  32'(m_ovf));
    chk({ctx, "_unf"},   32'(bus.underflow), 32'(m_unf));
  endtask

  // One clock: drive, take the edge, advance the model, check #1 later.
  task automatic cycle(input bit p, input bit po, input logic [W-1:0] d, input string ctx);
    int sz;
    bit pop_ok, push_ok;
    bus.push = p;
    bus.pop  = po;
    bus.in   = d;
    @(posedge clock);
    sz      = q.size();
    pop_ok  = po && (sz > 0);
    push_ok = p && ((sz < 8) || po);
    if (p && !push_ok) m_ovf = 1'b1;
    if (po && sz == 0) m_unf = 1'b1;
    if (pop_ok) void'(q.pop_front());
    if (push_ok) q.push_back(d);
    #1;
    check_all(ctx);
  endtask

  // Reset asserted between edges; outputs must clear before the next edge.
  task automatic async_reset(input string ctx);
    #2;
    reset = 1'b1;
    #1;
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    check_all(ctx);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    bus.in   = '0;
    bus.push = 1'b0;
    bus.pop  = 1'b0;

    // Power-on reset state, released away from a clock edge.
    #12;
    check_all("por");
    reset = 1'b0;

    // Three pushes: head is the first word.
    for (int i = 1; i <= 3; i++) cycle(1'b1, 1'b0, W'(i), "push3");
    chk("push3_head", 32'(bus.out), 32'h0001);

    // Fill to 8, ninth push dropped, drain all 8 in order.
    async_reset("rst_a");
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, W'(i), "fill8");
    cycle(1'b1, 1'b0, 16'h00FF, "push_full");
    chk("full_ovf", 32'(bus.overflow), 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("drain_word", 32'(bus.out), 32'(i));
      cycle(1'b0, 1'b1, '0, "drain8");
    end
    chk("drained_out", 32'(bus.out), 32'h0000);

    // Three fill/drain passes of five words walk the pointers past 7.
    async_reset("rst_b");
    for (int pass = 0; pass < 3; pass++) begin
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, W'(16'h0100 * (pass + 1) + i), "wrap_fill");
      for (int i = 0; i < 5; i++) begin
        chk("wrap_word", 32'(bus.out), 32'(16'h0100 * (pass + 1) + i));
        cycle(1'b0, 1'b1, '0, "wrap_drain");
      end
      chk("wrap_count0", 32'(bus.count), 32'd0);
    end

    // Simultaneous push/pop at empty, then at full.
    async_reset("rst_c");
    cycle(1'b1, 1'b1, 16'hABCD, "pp_empty");
    chk("pp_empty_out", 32'(bus.out), 32'hABCD);
    for (int i = 1; i < 8; i++) cycle(1'b1, 1'b0, W'(16'h0010 + i), "pp_fill");
    cycle(1'b1, 1'b1, 16'h1234, "pp_full");
    chk("pp_full_ovf", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, '0, "pp_drain");

    // Pop on empty: underflow sticks through idle cycles.
    async_reset("rst_d");
    cycle(1'b0, 1'b1, '0, "pop_empty");
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, '0, "unf_hold");
    chk("unf_sticky", 32'(bus.underflow), 32'd1);

    // Asynchronous reset with five words held, then restart from empty.
    async_reset("rst_e");
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, W'(16'h0A00 + i), "pre_arst");
    async_reset("mid_arst");
    cycle(1'b1, 1'b0, 16'h0042, "post_arst");
    chk("post_arst_out", 32'(bus.out), 32'h0042);
    cycle(1'b0, 1'b1, '0, "post_arst_pop");

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        async_reset("rnd_rst");
      end else begin
        cycle(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45),
              W'($urandom), "rnd");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
